// File: rtl/fdc_sector_server.sv
// Disk-side sector server for the NEC765 FDC core.
// Maps a drive/head/cylinder/sector request onto a flat byte-wide image and streams one 512-byte sector.
module fdc_sector_server #(
  parameter int unsigned SPT      = 9,
  parameter logic [7:0]  FIRST_ID = 8'hC1,
  parameter int unsigned TRACKS   = 40,
  parameter int unsigned SIDES    = 1,
  parameter logic [22:0] BASE_A   = 23'h000000,
  parameter logic [22:0] BASE_B   = 23'h040000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fdc_sr,
  output logic [31:0] fdc_cr,
  input  logic [1:0]  present,
  input  logic [1:0]  wp,
  output logic [7:0]  rd_data,
  output logic        rd_strobe,
  input  logic [7:0]  wr_data,
  input  logic        wr_avail,
  output logic        wr_strobe,
  output logic [22:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [2:0]  dbg_state
);

  // Memory handshake: mem_rd/mem_wr is a request held high until the single-cycle
  // mem_ack; the request drops on the edge that samples mem_ack, never both at once.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_PUSH = 3'd3;
  localparam logic [2:0] S_WR_POP  = 3'd4;
  localparam logic [2:0] S_WR_REQ  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [7:0]  id_q, id_d;
  logic [6:0]  cyl_q, cyl_d;
  logic        head_q, head_d;
  logic        wr_dir_q, wr_dir_d;
  logic        drive_q, drive_d;
  logic [22:0] base_q, base_d;
  logic [2:0]  cr_q, cr_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_strobe_q, rd_strobe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [22:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  logic        req_rd, req_wr, req_any;
  logic        chk_nf, chk_wp;
  logic [22:0] lin_sector, sector_addr;
  logic [8:0]  cnt_inc;
  logic        unused_sr;

  assign req_rd  = fdc_sr[17] | fdc_sr[18];
  assign req_wr  = fdc_sr[20] | fdc_sr[21];
  assign req_any = req_rd | req_wr;
  assign unused_sr = ^{fdc_sr[31:22], fdc_sr[19], fdc_sr[16]};

  assign chk_nf = !present[drive_q]
               || (32'(cyl_q) >= TRACKS)
               || (32'(head_q) >= SIDES)
               || (id_q < FIRST_ID)
               || (32'(id_q) >= 32'(FIRST_ID) + SPT);
  assign chk_wp = wr_dir_q && wp[drive_q];

  // Linear sector index within the image; the byte address wraps at 23 bits.
  assign lin_sector  = (23'(cyl_q) * 23'(SIDES) + 23'(head_q)) * 23'(SPT) + 23'(id_q - FIRST_ID);
  assign sector_addr = (drive_q ? BASE_B : BASE_A) + (lin_sector << 9);
  assign cnt_inc     = cnt_q + 9'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    cyl_d       = cyl_q;
    head_d      = head_q;
    wr_dir_d    = wr_dir_q;
    drive_d     = drive_q;
    base_d      = base_q;
    cr_d        = cr_q;
    rd_data_d   = rd_data_q;
    rd_strobe_d = 1'b0;
    wr_strobe_d = 1'b0;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          id_d     = fdc_sr[7:0];
          cyl_d    = fdc_sr[14:8];
          head_d   = fdc_sr[15];
          wr_dir_d = !req_rd;
          drive_d  = req_rd ? !fdc_sr[17] : !fdc_sr[20];
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d = 9'd0;
        if (chk_nf || chk_wp) begin
          cr_d    = {1'b1, chk_nf, chk_wp};
          state_d = S_DONE;
        end else begin
          base_d     = sector_addr;
          mem_addr_d = sector_addr;
          if (wr_dir_q) begin
            state_d = S_WR_POP;
          end else begin
            mem_rd_d = 1'b1;
            state_d  = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (mem_ack) begin
          rd_data_d   = mem_rdata;
          mem_rd_d    = 1'b0;
          rd_strobe_d = 1'b1;
          state_d     = S_RD_PUSH;
        end
      end
      S_RD_PUSH: begin
        if (cnt_q == 9'd511) begin
          cr_d    = 3'b100;
          state_d = S_DONE;
        end else begin
          cnt_d      = cnt_inc;
          mem_addr_d = base_q + 23'(cnt_inc);
          mem_rd_d   = 1'b1;
          state_d    = S_RD_REQ;
        end
      end
      S_WR_POP: begin
        if (wr_avail) begin
          mem_wdata_d = wr_data;
          wr_strobe_d = 1'b1;
          mem_addr_d  = base_q + 23'(cnt_q);
          mem_wr_d    = 1'b1;
          state_d     = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (mem_ack) begin
          mem_wr_d = 1'b0;
          if (cnt_q == 9'd511) begin
            cr_d    = 3'b100;
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_inc;
            state_d = S_WR_POP;
          end
        end
      end
      S_DONE: begin
        if (!req_any) begin
          cr_d    = 3'b000;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 9'd0;
      id_q        <= 8'd0;
      cyl_q       <= 7'd0;
      head_q      <= 1'b0;
      wr_dir_q    <= 1'b0;
      drive_q     <= 1'b0;
      base_q      <= 23'd0;
      cr_q        <= 3'd0;
      rd_data_q   <= 8'd0;
      rd_strobe_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 23'd0;
      mem_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      cyl_q       <= cyl_d;
      head_q      <= head_d;
      wr_dir_q    <= wr_dir_d;
      drive_q     <= drive_d;
      base_q      <= base_d;
      cr_q        <= cr_d;
      rd_data_q   <= rd_data_d;
      rd_strobe_q <= rd_strobe_d;
      wr_strobe_q <= wr_strobe_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign fdc_cr    = {27'd0, cr_q, 2'b00};
  assign rd_data   = rd_data_q;
  assign rd_strobe = rd_strobe_q;
  assign wr_strobe = wr_strobe_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fdc_sector_server.sv
// Directed, table-driven bench for fdc_sector_server with a zero-wait memory model
// and an FDC output-FIFO model whose head byte is 0xA5 ^ index.
module tb_fdc_sector_server;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fdc_sr = 32'd0;
  logic [31:0] fdc_cr;
  logic [1:0]  present = 2'b11;
  logic [1:0]  wp = 2'b00;
  logic [7:0]  rd_data;
  logic        rd_strobe;
  logic [7:0]  wr_data;
  logic        wr_avail;
  logic        wr_strobe;
  logic [22:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack = 1'b0;
  logic [2:0]  dbg_state;

  logic        fifo_rst = 1'b1;
  logic        fifo_tog = 1'b0;
  logic [9:0]  fifo_idx = 10'd0;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] sr;
    logic [1:0]  pres;
    logic [1:0]  wpv;
    logic [7:0]  cr;
    int          n;
    logic [22:0] base;
    logic        wr;
  } vec_t;

  vec_t vecs[11];

  fdc_sector_server dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fdc_sr    (fdc_sr),
    .fdc_cr    (fdc_cr),
    .present   (present),
    .wp        (wp),
    .rd_data   (rd_data),
    .rd_strobe (rd_strobe),
    .wr_data   (wr_data),
    .wr_avail  (wr_avail),
    .wr_strobe (wr_strobe),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Zero-wait memory: ack one cycle after a request, image byte[i] = i[7:0]
  always @(posedge clk) mem_ack <= (mem_rd | mem_wr) & ~mem_ack;
  assign mem_rdata = mem_addr[7:0];

  // FDC output FIFO: data available every other cycle
  always @(posedge clk) begin
    if (fifo_rst) begin
      fifo_tog <= 1'b0;
      fifo_idx <= 10'd0;
    end else begin
      fifo_tog <= ~fifo_tog;
      if (wr_strobe) fifo_idx <= fifo_idx + 10'd1;
    end
  end
  assign wr_avail = fifo_tog;
  assign wr_data  = 8'hA5 ^ fifo_idx[7:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_req(input string tag, input vec_t v);
    logic [7:0]  exp_q[$];
    logic [22:0] first_a, last_a;
    logic        seen, done;
    int c, done_c, nrd, nwr, nrdtx, nwrtx, both, widx;
    present = v.pres;
    wp = v.wpv;
    fifo_rst = 1'b1;
    @(negedge clk);
    fifo_rst = 1'b0;
    for (int i = 0; i < v.n; i++)
      exp_q.push_back(v.wr ? (8'hA5 ^ 8'(i)) : 8'(v.base + 23'(i)));
    first_a = '0; last_a = '0; seen = 1'b0; done = 1'b0;
    c = 0; done_c = 0; nrd = 0; nwr = 0; nrdtx = 0; nwrtx = 0; both = 0; widx = 0;
    fdc_sr = v.sr;
    while (!done && c < 6000) begin
      @(negedge clk);
      c++;
      if (mem_rd && mem_wr) both++;
      if ((mem_rd || mem_wr) && !seen) begin
        first_a = mem_addr;
        seen = 1'b1;
      end
      if (mem_rd && mem_ack) begin
        nrdtx++;
        last_a = mem_addr;
      end
      if (rd_strobe) begin
        nrd++;
        if (exp_q.size() > 0) check({tag, "_rd_data"}, {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        else check({tag, "_rd_extra"}, nrd, v.n);
      end
      if (mem_wr && mem_ack) begin
        nwrtx++;
        check({tag, "_wr_addr"}, {9'd0, mem_addr}, {9'd0, v.base + 23'(widx)});
        if (exp_q.size() > 0) check({tag, "_wr_data"}, {24'd0, mem_wdata}, {24'd0, exp_q.pop_front()});
        else check({tag, "_wr_extra"}, nwrtx, v.n);
        widx++;
      end
      if (wr_strobe) nwr++;
      if (fdc_cr[4]) begin
        done = 1'b1;
        done_c = c;
      end
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_cr"}, fdc_cr, {24'd0, v.cr});
    check({tag, "_rd_strobes"}, nrd, v.wr ? 0 : v.n);
    check({tag, "_rd_txn"}, nrdtx, v.wr ? 0 : v.n);
    check({tag, "_wr_strobes"}, nwr, v.wr ? v.n : 0);
    check({tag, "_wr_txn"}, nwrtx, v.wr ? v.n : 0);
    check({tag, "_rd_wr_overlap"}, both, 0);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    if (v.n > 0) check({tag, "_first_addr"}, {9'd0, first_a}, {9'd0, v.base});
    else check({tag, "_latency"}, {31'd0, done_c <= 2}, 32'd1);
    if (v.n > 0 && !v.wr) check({tag, "_last_addr"}, {9'd0, last_a}, {9'd0, v.base + 23'd511});
    fdc_sr = 32'd0;
    @(negedge clk);
    check({tag, "_cr_clear"}, fdc_cr, 32'd0);
    check({tag, "_idle"}, {29'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    int cnt;
    // sr, present, wp, cr, bytes, first address, write
    vecs[0]  = '{32'h000202C3, 2'b11, 2'b00, 8'h10, 512, 23'h002800, 1'b0}; // read hit A cyl2 C3
    vecs[1]  = '{32'h000202CA, 2'b11, 2'b00, 8'h18, 0,   23'h000000, 1'b0}; // ID past track
    vecs[2]  = '{32'h002000C1, 2'b11, 2'b00, 8'h10, 512, 23'h040000, 1'b1}; // write B
    vecs[3]  = '{32'h001000C1, 2'b11, 2'b01, 8'h14, 0,   23'h000000, 1'b1}; // write-protected A
    vecs[4]  = '{32'h001200C1, 2'b11, 2'b00, 8'h10, 512, 23'h000000, 1'b0}; // read beats write
    vecs[5]  = '{32'h000200C1, 2'b10, 2'b00, 8'h18, 0,   23'h000000, 1'b0}; // A absent
    vecs[6]  = '{32'h000228C1, 2'b11, 2'b00, 8'h18, 0,   23'h000000, 1'b0}; // cyl 40
    vecs[7]  = '{32'h000280C1, 2'b11, 2'b00, 8'h18, 0,   23'h000000, 1'b0}; // head 1, single side
    vecs[8]  = '{32'h000200C0, 2'b11, 2'b00, 8'h18, 0,   23'h000000, 1'b0}; // ID below first
    vecs[9]  = '{32'h000427C9, 2'b11, 2'b00, 8'h10, 512, 23'h06CE00, 1'b0}; // read B cyl39 C9
    vecs[10] = '{32'h001001C5, 2'b11, 2'b10, 8'h10, 512, 23'h001A00, 1'b1}; // write A, B protected

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cr", fdc_cr, 32'd0);
    check("rst_mem", {29'd0, mem_rd, mem_wr, rd_strobe}, 32'd0);
    check("rst_addr", {9'd0, mem_addr}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 11; k++) run_req($sformatf("v%0d", k), vecs[k]);

    // Reset in the middle of a read after 100 bytes
    present = 2'b11;
    wp = 2'b00;
    fdc_sr = 32'h000202C3;
    cnt = 0;
    for (int c = 0; c < 2000 && cnt < 100; c++) begin
      @(negedge clk);
      if (rd_strobe) cnt++;
    end
    check("midrst_bytes", cnt, 100);
    rst_n = 1'b0;
    fdc_sr = 32'd0;
    @(negedge clk);
    check("midrst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("midrst_strobes", {30'd0, rd_strobe, wr_strobe}, 32'd0);
    check("midrst_cr", fdc_cr, 32'd0);
    check("midrst_addr", {9'd0, mem_addr}, 32'd0);
    check("midrst_data", {16'd0, rd_data, mem_wdata}, 32'd0);
    check("midrst_state", {29'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_req("after_rst", vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
